cacheline_adaptor: RTL and testbench

Responder for the cache's physical-memory port: accepts one 256-bit line read or write request (`pmem_read`/`pmem_write`, `pmem_address`, `pmem_wdata`) and completes it as a four-beat, 64-bit burst on the main-memory interface. On completion it returns `pmem_rdata` and a single-cycle `pmem_resp`. It sits between the cache datapath/control and the burst memory model, one instance per cache.

---
 rtl/cacheline_adaptor_if.sv | 33 +++
 rtl/cacheline_adaptor.sv | 84 ++++++++
 tb/tb_cacheline_adaptor.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_if.sv
// Cache physical-memory port plus the 64-bit burst memory port, bundled.
// The adaptor takes the slave view; the cache/memory environment takes master.
interface cacheline_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
);
    logic                   pmem_read;
    logic                   pmem_write;
    logic [31:0]            pmem_address;
    logic [LINE_WIDTH-1:0]  pmem_wdata;
    logic [LINE_WIDTH-1:0]  pmem_rdata;
    logic                   pmem_resp;
    logic [31:0]            burst_address;
    logic                   burst_read;
    logic                   burst_write;
    logic [BURST_WIDTH-1:0] burst_wdata;
    logic [BURST_WIDTH-1:0] burst_rdata;
    logic                   burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        output burst_address, burst_read, burst_write, burst_wdata,
        input  burst_rdata, burst_resp
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        input  burst_address, burst_read, burst_write, burst_wdata,
        output burst_rdata, burst_resp
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one cache-line read/write into a fixed four-beat burst on main memory,
// buffering the line locally and pulsing pmem_resp once the last beat lands.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    cacheline_adaptor_if.slave  bus
);
    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam int OFS   = $clog2(LINE_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [31:0]           addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                // Read has priority if the cache ever raises both.
                if (bus.pmem_read) begin
                    addr_d  = {bus.pmem_address[31:OFS], {OFS{1'b0}}};
                    cnt_d   = '0;
                    state_d = READ;
                end else if (bus.pmem_write) begin
                    addr_d  = {bus.pmem_address[31:OFS], {OFS{1'b0}}};
                    buf_d   = bus.pmem_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (bus.burst_resp) begin
                    buf_d[BURST_WIDTH*cnt_q +: BURST_WIDTH] = bus.burst_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            WRITE: begin
                if (bus.burst_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.burst_read    = (state_q == READ);
    assign bus.burst_write   = (state_q == WRITE);
    assign bus.burst_address = addr_q;
    // Beat slice is held steady across stalls because cnt_q only moves on burst_resp.
    assign bus.burst_wdata   = (state_q == WRITE) ? buf_q[BURST_WIDTH*cnt_q +: BURST_WIDTH]
                                                  : '0;
    assign bus.pmem_resp     = (state_q == DONE);
    assign bus.pmem_rdata    = buf_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized line transactions against a queue-based memory model.
module tb_cacheline_adaptor;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [255:0] exp_line;

    always #5 clk = ~clk;

    cacheline_adaptor_if #(.LINE_WIDTH(256), .BURST_WIDTH(64)) bus ();

    cacheline_adaptor #(.LINE_WIDTH(256), .BURST_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk1({tag, " burst_read"}, bus.burst_read, 1'b0);
        chk1({tag, " burst_write"}, bus.burst_write, 1'b0);
        chk1({tag, " pmem_resp"}, bus.pmem_resp, 1'b0);
        chk({tag, " pmem_rdata"}, bus.pmem_rdata, exp_line);
    endtask

    // Caller leaves the DUT idle at a negedge; returns at the negedge of the
    // idle cycle following DONE with requests already dropped.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wdata,
                           input int gaps[4], input bit scramble, input bit fixed_beats);
        logic [63:0]  beats[$];
        logic [63:0]  wq[$];
        logic [255:0] tmp;
        tmp = wdata;
        for (int k = 0; k < 4; k++) begin
            wq.push_back(tmp[63:0]);
            tmp = tmp >> 64;
            if (fixed_beats) beats.push_back({16{4'(k)}});
            else             beats.push_back({$urandom, $urandom});
        end
        bus.pmem_read    = !wr;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = wdata;
        bus.burst_resp   = 1'b0;
        @(negedge clk);
        chk("burst_address", 256'(bus.burst_address), 256'(addr & 32'hFFFF_FFE0));
        if (scramble) begin
            bus.pmem_wdata   = '0;
            bus.pmem_address = $urandom;
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g <= gaps[k]; g++) begin
                bus.burst_resp  = (g == gaps[k]);
                bus.burst_rdata = (g == gaps[k]) ? beats[k] : {$urandom, $urandom};
                chk1("burst_read held", bus.burst_read, !wr);
                chk1("burst_write held", bus.burst_write, wr);
                chk1("pmem_resp early", bus.pmem_resp, 1'b0);
                if (wr) chk("burst_wdata beat", 256'(bus.burst_wdata), 256'(wq[k]));
                @(negedge clk);
            end
        end
        bus.burst_resp = 1'b0;
        exp_line = wr ? wdata : {beats[3], beats[2], beats[1], beats[0]};
        chk1("pmem_resp done", bus.pmem_resp, 1'b1);
        chk1("burst_read after", bus.burst_read, 1'b0);
        chk1("burst_write after", bus.burst_write, 1'b0);
        chk("pmem_rdata line", bus.pmem_rdata, exp_line);
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        @(negedge clk);
        idle_checks("post-done");
    endtask

    initial begin
        int gaps[4];
        logic [255:0] wline;
        rst = 1'b1;
        bus.pmem_read    = 1'b1;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 32'hCAFE_0040;
        bus.pmem_wdata   = '0;
        bus.burst_rdata  = '0;
        bus.burst_resp   = 1'b0;
        exp_line = '0;

        // Reset held two cycles with a pending read.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle_checks("reset");
            chk("reset burst_wdata", 256'(bus.burst_wdata), 256'(0));
            chk("reset burst_address", 256'(bus.burst_address), 256'(0));
        end
        rst = 1'b0;
        @(negedge clk);
        chk1("read after reset", bus.burst_read, 1'b1);
        chk("addr after reset", 256'(bus.burst_address), 256'(32'hCAFE_0040));
        rst = 1'b1;
        bus.pmem_read = 1'b0;
        @(negedge clk);
        idle_checks("abort");
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back read with fixed beats.
        gaps = '{0, 0, 0, 0};
        run_txn(1'b0, 32'h1234_56F7, '0, gaps, 1'b0, 1'b1);
        chk("fixed read line", bus.pmem_rdata,
            {{16{4'h3}}, {16{4'h2}}, {16{4'h1}}, {16{4'h0}}});

        // Write with input changed after acceptance and a stall before beat 2.
        wline = 256'hDEADBEEF_CAFEF00D_01234567_89ABCDEF_FEDCBA98_76543210_0BADC0DE_00000001;
        gaps = '{0, 0, 3, 0};
        run_txn(1'b1, 32'h0000_1F3C, wline, gaps, 1'b1, 1'b0);

        // Idle noise on burst_resp.
        for (int c = 0; c < 12; c++) begin
            bus.burst_resp  = 1'($urandom);
            bus.burst_rdata = {$urandom, $urandom};
            @(negedge clk);
            idle_checks("idle noise");
        end
        bus.burst_resp = 1'b0;

        // Reset mid-read after beat 1.
        bus.pmem_read    = 1'b1;
        bus.pmem_address = $urandom;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        bus.burst_resp = 1'b0;
        bus.pmem_read  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        exp_line = '0;
        idle_checks("mid-read reset");
        chk("mid-read reset addr", 256'(bus.burst_address), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        idle_checks("after reset");
        gaps = '{1, 0, 2, 0};
        run_txn(1'b0, $urandom, '0, gaps, 1'b0, 1'b0);

        // Read then write back-to-back.
        gaps = '{0, 0, 0, 0};
        run_txn(1'b0, $urandom, '0, gaps, 1'b0, 1'b0);
        run_txn(1'b1, $urandom, {8{$urandom}}, gaps, 1'b0, 1'b0);

        // Randomized mix.
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < 4; k++) gaps[k] = int'($urandom_range(0, 3));
            run_txn(1'($urandom), $urandom, {8{$urandom}}, gaps, 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
